// File: rtl/cnt_cmd_seq_if.sv
// Command channel between a controller and cnt_cmd_seq: valid/ready handshake
// carrying an opcode and its argument.
interface cnt_cmd_seq_if #(
  parameter int ARG_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [ARG_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cnt_cmd_seq.sv
// Buffers LOAD/UP/DOWN/PAUSE commands and replays them as registered load/din/en/m
// strobes for an up/down counter. Define CNT_CMD_SEQ_SHADOW_EN for exp_count/wrap_flag.
module cnt_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int ARG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  cnt_cmd_seq_if.slave           cmd,
  input  logic                   flush,
  output logic                   cnt_load,
  output logic [ARG_W-1:0]       cnt_din,
  output logic                   cnt_en,
  output logic                   cnt_m,
  output logic                   busy,
  output logic                   cmd_done,
  output logic [$clog2(DEPTH):0] level
`ifdef CNT_CMD_SEQ_SHADOW_EN
  ,
  output logic [ARG_W-1:0]       exp_count,
  output logic                   wrap_flag
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [ARG_W-1:0] ARG_ZERO  = {ARG_W{1'b0}};
  localparam logic [ARG_W-1:0] ARG_ONE   = ARG_W'(1);
  localparam logic [1:0]       OP_LOAD   = 2'b00;
  localparam logic [1:0]       OP_UP     = 2'b01;
  localparam logic [1:0]       OP_DOWN   = 2'b10;
  localparam logic [1:0]       OP_PAUSE  = 2'b11;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_e;

  logic [1:0]       op_mem_r  [DEPTH];
  logic [ARG_W-1:0] arg_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r;

  state_e           state_r, state_nx_s;
  logic [ARG_W-1:0] remain_r, remain_nx_s;
  logic [ARG_W-1:0] din_r, din_nx_s;
  logic             load_r, load_nx_s;
  logic             en_r, en_nx_s;
  logic             m_r, m_nx_s;
  logic             done_r, done_nx_s;

  logic             ready_s, push_s, pop_s, fifo_empty_s;
  logic [1:0]       head_op_s;
  logic [ARG_W-1:0] head_arg_s;
  logic [ARG_W-1:0] head_rem_s;

  assign fifo_empty_s  = (level_r == LVL_ZERO);
  assign ready_s       = (level_r != LVL_FULL) && !flush;
  assign push_s        = cmd.cmd_valid && ready_s;
  assign head_op_s     = op_mem_r[rd_ptr_r];
  assign head_arg_s    = arg_mem_r[rd_ptr_r];
  assign head_rem_s    = (head_arg_s == ARG_ZERO) ? ARG_ZERO : (head_arg_s - ARG_ONE);
  assign cmd.cmd_ready = ready_s;

  // FIFO storage write; entries need no reset since level_r gates their use
  always_ff @(posedge clk) begin
    if (push_s) begin
      op_mem_r[wr_ptr_r]  <= cmd.cmd_op;
      arg_mem_r[wr_ptr_r] <= cmd.cmd_arg;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      level_r  <= level_r + (push_s ? LVL_ONE : LVL_ZERO) - (pop_s ? LVL_ONE : LVL_ZERO);
    end
  end

  // Next state and next strobe values; a command's last cycle is the one with done_r set
  always_comb begin
    state_nx_s  = state_r;
    remain_nx_s = remain_r;
    din_nx_s    = din_r;
    load_nx_s   = 1'b0;
    en_nx_s     = en_r;
    m_nx_s      = m_r;
    done_nx_s   = 1'b0;
    pop_s       = 1'b0;
    if (flush) begin
      state_nx_s  = ST_IDLE;
      en_nx_s     = 1'b0;
      remain_nx_s = ARG_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          en_nx_s = 1'b0;
          pop_s   = !fifo_empty_s;
        end
        ST_EXEC: begin
          if (done_r) begin
            state_nx_s = ST_IDLE;
            en_nx_s    = 1'b0;
            pop_s      = !fifo_empty_s;
          end else begin
            remain_nx_s = remain_r - ARG_ONE;
            done_nx_s   = (remain_r == ARG_ONE);
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          en_nx_s    = 1'b0;
        end
      endcase
      if (pop_s) begin
        state_nx_s = ST_EXEC;
        case (head_op_s)
          OP_LOAD: begin
            load_nx_s   = 1'b1;
            din_nx_s    = head_arg_s;
            en_nx_s     = 1'b0;
            done_nx_s   = 1'b1;
            remain_nx_s = ARG_ZERO;
          end
          OP_UP, OP_DOWN: begin
            m_nx_s      = (head_op_s == OP_DOWN);
            en_nx_s     = (head_arg_s != ARG_ZERO);
            done_nx_s   = (head_arg_s <= ARG_ONE);
            remain_nx_s = head_rem_s;
          end
          OP_PAUSE: begin
            en_nx_s     = 1'b0;
            done_nx_s   = (head_arg_s <= ARG_ONE);
            remain_nx_s = head_rem_s;
          end
          default: begin
            en_nx_s     = 1'b0;
            done_nx_s   = 1'b1;
            remain_nx_s = ARG_ZERO;
          end
        endcase
      end else begin
        load_nx_s = 1'b0;
      end
    end
  end

  // Sequencer state and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      remain_r <= ARG_ZERO;
      din_r    <= ARG_ZERO;
      load_r   <= 1'b0;
      en_r     <= 1'b0;
      m_r      <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      remain_r <= remain_nx_s;
      din_r    <= din_nx_s;
      load_r   <= load_nx_s;
      en_r     <= en_nx_s;
      m_r      <= m_nx_s;
      done_r   <= done_nx_s;
    end
  end

  assign cnt_load = load_r;
  assign cnt_din  = din_r;
  assign cnt_en   = en_r;
  assign cnt_m    = m_r;
  assign cmd_done = done_r;
  assign level    = level_r;
  assign busy     = (state_r == ST_EXEC) || !fifo_empty_s;

`ifdef CNT_CMD_SEQ_SHADOW_EN
  localparam logic [ARG_W-1:0] ARG_ONES = {ARG_W{1'b1}};
  logic [ARG_W-1:0] shadow_r;
  logic             wrap_r;

  // Track the counter, which samples our registered strobes on every edge
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= ARG_ZERO;
      wrap_r   <= 1'b0;
    end else if (load_r) begin
      shadow_r <= din_r;
      wrap_r   <= wrap_r;
    end else if (en_r && !m_r) begin
      shadow_r <= shadow_r + ARG_ONE;
      wrap_r   <= wrap_r || (shadow_r == ARG_ONES);
    end else if (en_r && m_r) begin
      shadow_r <= shadow_r - ARG_ONE;
      wrap_r   <= wrap_r || (shadow_r == ARG_ZERO);
    end else begin
      shadow_r <= shadow_r;
      wrap_r   <= wrap_r;
    end
  end

  assign exp_count = shadow_r;
  assign wrap_flag = wrap_r;
`endif

endmodule

// File: tb/tb_cnt_cmd_seq.sv
// Self-checking bench for cnt_cmd_seq: directed vector table, hand-written corner
// sequences and random traffic against a command-expansion reference model.
module tb_cnt_cmd_seq;
  localparam int DEPTH = 4;
  localparam int ARG_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       cnt_load, cnt_en, cnt_m, busy, cmd_done;
  logic [7:0] cnt_din;
  logic [2:0] level;
`ifdef CNT_CMD_SEQ_SHADOW_EN
  logic [7:0] exp_count;
  logic       wrap_flag;
`endif

  cnt_cmd_seq_if #(.ARG_W(ARG_W)) cmd_if ();

  cnt_cmd_seq #(.DEPTH(DEPTH), .ARG_W(ARG_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .flush(flush),
    .cnt_load(cnt_load), .cnt_din(cnt_din), .cnt_en(cnt_en), .cnt_m(cnt_m),
    .busy(busy), .cmd_done(cmd_done), .level(level)
`ifdef CNT_CMD_SEQ_SHADOW_EN
    , .exp_count(exp_count), .wrap_flag(wrap_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: FIFO of commands, each expanded into its per-cycle strobe list when popped
  typedef struct packed {logic [1:0] op; logic [7:0] arg;} cmd_t;
  typedef struct packed {logic load; logic [7:0] din; logic en; logic m; logic done;} strobe_t;
  cmd_t       mq[$];
  strobe_t    sched[$];
  strobe_t    cur = '0;
  logic       cur_exec = 1'b0;
  logic [7:0] m_din = 8'd0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_wrap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  function automatic void expand(input cmd_t c);
    strobe_t s;
    if (c.op == 2'b00) begin
      s = '0; s.load = 1'b1; s.din = c.arg; s.done = 1'b1;
      sched.push_back(s);
    end else if (c.arg == 8'd0) begin
      s = '0; s.done = 1'b1;
      sched.push_back(s);
    end else begin
      for (int i = 0; i < int'(c.arg); i++) begin
        s = '0;
        s.en   = (c.op != 2'b11);
        s.m    = (c.op == 2'b10);
        s.done = (i == int'(c.arg) - 1);
        sched.push_back(s);
      end
    end
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [1:0] op,
                            input logic [7:0] arg, input logic f);
    logic push;
    if (r) begin
      mq.delete(); sched.delete();
      cur = '0; cur_exec = 1'b0; m_din = 8'd0; m_cnt = 8'd0; m_wrap = 1'b0;
    end else begin
      if (cur.load) m_cnt = cur.din;
      else if (cur.en && !cur.m) begin m_wrap = m_wrap | (m_cnt == 8'd255); m_cnt = m_cnt + 8'd1; end
      else if (cur.en && cur.m) begin m_wrap = m_wrap | (m_cnt == 8'd0); m_cnt = m_cnt - 8'd1; end
      push = v && (mq.size() < DEPTH) && !f;
      if (f) begin
        mq.delete(); sched.delete(); cur = '0; cur_exec = 1'b0;
      end else begin
        if (sched.size() == 0 && mq.size() > 0) expand(mq.pop_front());
        if (sched.size() > 0) begin cur = sched.pop_front(); cur_exec = 1'b1; end
        else begin cur = '0; cur_exec = 1'b0; end
        if (push) mq.push_back({op, arg});
        if (cur.load) m_din = cur.din;
      end
    end
  endtask

  task automatic compare_model();
    logic       busy_e;
    logic [2:0] lvl_e;
    busy_e = cur_exec || (mq.size() != 0);
    lvl_e  = 3'(mq.size());
    check("cycle", 32'({cnt_load, cnt_din, cnt_en, cmd_done, busy, level}),
          32'({cur.load, m_din, cur.en, cur.done, busy_e, lvl_e}));
    if (cur.en) check("dir", 32'(cnt_m), 32'(cur.m));
`ifdef CNT_CMD_SEQ_SHADOW_EN
    check("shadow", 32'({wrap_flag, exp_count}), 32'({m_wrap, m_cnt}));
`endif
  endtask

  // One clock: drive inputs, check cmd_ready, advance model with the DUT, compare
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [7:0] arg, input logic f);
    rst = r; flush = f;
    cmd_if.cmd_valid = v; cmd_if.cmd_op = op; cmd_if.cmd_arg = arg;
    #1;
    if (!r) check("cmd_ready", 32'(cmd_if.cmd_ready), 32'((mq.size() < DEPTH) && !f));
    @(posedge clk);
    model_edge(r, v, op, arg, f);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'd0, 1'b0);
  endtask

  typedef struct {
    logic rst; logic valid; logic [1:0] op; logic [7:0] arg; logic flush;
    logic load; logic [7:0] din; logic en; logic m; logic done; logic busy; logic [2:0] lvl;
  } vec_t;
  vec_t vec[16];

  initial begin
    logic acc;
    int   n;

    //         rst   vld   op     arg     fl    | load  din     en    m     done  busy  lvl
    vec[0]  = '{1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vec[1]  = '{1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vec[2]  = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vec[3]  = '{1'b0, 1'b1, 2'd0, 8'd100, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    vec[4]  = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
    vec[5]  = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vec[6]  = '{1'b0, 1'b1, 2'd0, 8'd200, 1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    vec[7]  = '{1'b0, 1'b1, 2'd1, 8'd3,   1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    vec[8]  = '{1'b0, 1'b1, 2'd2, 8'd2,   1'b0, 1'b0, 8'd200, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
    vec[9]  = '{1'b0, 1'b1, 2'd3, 8'd1,   1'b0, 1'b0, 8'd200, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2};
    vec[10] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd200, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
    vec[11] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd200, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
    vec[12] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd200, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1};
    vec[13] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd200, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
    vec[14] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd200, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[15] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 8'd200, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

    for (int i = 0; i < 16; i++) begin
      step(vec[i].rst, vec[i].valid, vec[i].op, vec[i].arg, vec[i].flush);
      check($sformatf("vec%0d", i),
            32'({cnt_load, cnt_din, cnt_en, cnt_m, cmd_done, busy, level}),
            32'({vec[i].load, vec[i].din, vec[i].en, vec[i].m, vec[i].done, vec[i].busy, vec[i].lvl}));
    end
    check("after_reset_ready", 32'(cmd_if.cmd_ready), 32'd1);
`ifdef CNT_CMD_SEQ_SHADOW_EN
    check("seq_shadow_201", 32'(exp_count), 32'd201);
`endif

    // Stall on UP 255, fill the FIFO, hold an extra command until a slot frees
    step(1'b0, 1'b1, 2'd1, 8'd255, 1'b0);
    idle(1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 2'd1, 8'd1, 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));
    n = 0;
    do begin
      acc = (mq.size() < DEPTH);
      if (n == 2) check("full_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
      step(1'b0, 1'b1, 2'd0, 8'd9, 1'b0);
      n++;
    end while (!acc && n < 400);
    check("held_cmd_accepted", 32'(acc), 32'd1);
    check("held_wait_cycles", 32'(n > 200), 32'd1);
    idle(12);
    check("drain_din", 32'(cnt_din), 32'd9);

    // Flush in the 2nd cycle of UP 5 with two commands queued
    step(1'b0, 1'b1, 2'd1, 8'd5, 1'b0);
    step(1'b0, 1'b1, 2'd0, 8'd7, 1'b0);
    step(1'b0, 1'b1, 2'd1, 8'd2, 1'b0);
    step(1'b0, 1'b1, 2'd2, 8'd3, 1'b1);
    check("flush_state", 32'({cnt_en, cnt_load, cmd_done, busy, level}), 32'd0);
    idle(3);

    // Reset in the middle of DOWN 4
    step(1'b0, 1'b1, 2'd2, 8'd4, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    check("rst_state", 32'({cnt_load, cnt_din, cnt_en, cnt_m, cmd_done, busy, level}), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    idle(2);

`ifdef CNT_CMD_SEQ_SHADOW_EN
    step(1'b0, 1'b1, 2'd0, 8'd255, 1'b0);
    step(1'b0, 1'b1, 2'd1, 8'd1, 1'b0);
    idle(3);
    check("wrap_up", 32'({wrap_flag, exp_count}), 32'h100);
    step(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    check("wrap_after_flush", 32'(wrap_flag), 32'd1);
    step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    check("wrap_after_rst", 32'(wrap_flag), 32'd0);
    step(1'b0, 1'b1, 2'd0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 8'd1, 1'b0);
    idle(3);
    check("wrap_down", 32'({wrap_flag, exp_count}), 32'h1ff);
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), 2'($urandom),
           ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4)),
           $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
